// File: rtl/ofs_fim_pcie_ss_sb_tx_arb.sv
// ofs_fim_pcie_ss_sb_tx_arb
// Packet-atomic round-robin arbiter that merges NUM_PORTS side-band-header
// AXI-Stream TX streams into one output stream. Each packet costs one IDLE
// arbitration cycle, and the grant is held until the tlast beat is accepted.
// In LOCKED, the granted requester is wired straight through to out_* with no
// added latency.
// Optional feature: define OFS_FIM_PCIE_SS_SB_ARB_STATS_EN to add per-port
// 32-bit accepted-packet counters on the pkt_count output.
module ofs_fim_pcie_ss_sb_tx_arb #(
  parameter int NUM_PORTS   = 2,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 266,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int KW = TDATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_PORTS*KW-1:0]          in_tkeep,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] in_tuser_vendor,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic [TDATA_WIDTH-1:0]           out_tdata,
  output logic [KW-1:0]                    out_tkeep,
  output logic                             out_tlast,
  output logic [TUSER_WIDTH-1:0]           out_tuser_vendor,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
`ifdef OFS_FIM_PCIE_SS_SB_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          pkt_count
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_next;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic [GW-1:0] next_ptr;
  logic          any_valid;
  logic          pkt_done;

  assign any_valid = |in_tvalid;
  assign busy      = (state == LOCKED);
  assign pkt_done  = (state == LOCKED) && out_tvalid && out_tready && out_tlast;
  assign next_ptr  = (grant_id == GW'(NUM_PORTS - 1)) ? '0 : grant_id + GW'(1);

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [GW:0] sum;
    logic        found;
    winner = rr_ptr;
    found  = 1'b0;
    sum    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (sum >= (GW+1)'(NUM_PORTS)) begin
        sum = sum - (GW+1)'(NUM_PORTS);
      end
      if (!found && in_tvalid[sum[GW-1:0]]) begin
        found  = 1'b1;
        winner = sum[GW-1:0];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until tlast is accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = LOCKED;
      LOCKED:  if (pkt_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_valid) begin
        grant_id <= winner;
      end
      if (pkt_done) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  // Data path always follows grant_id. Only the handshake is gated by state,
  // so the payload is passed through unmodified.
  assign out_tdata        = in_tdata[grant_id*TDATA_WIDTH +: TDATA_WIDTH];
  assign out_tkeep        = in_tkeep[grant_id*KW +: KW];
  assign out_tuser_vendor = in_tuser_vendor[grant_id*TUSER_WIDTH +: TUSER_WIDTH];
  assign out_tlast        = in_tlast[grant_id];

  // Handshake routing: only the granted requester sees out_tready, only in LOCKED.
  always_comb begin
    in_tready  = '0;
    out_tvalid = 1'b0;
    if (state == LOCKED) begin
      out_tvalid          = in_tvalid[grant_id];
      in_tready[grant_id] = out_tready;
    end
  end

`ifdef OFS_FIM_PCIE_SS_SB_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [31:0] cnt;
      // Count accepted tlast beats of this port; wraps naturally at 2^32.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (pkt_done && (grant_id == GW'(gi))) begin
          cnt <= cnt + 32'd1;
        end
      end
      assign pkt_count[gi*32 +: 32] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb_tx_arb.sv
// Directed testbench for ofs_fim_pcie_ss_sb_tx_arb with four small ports.
// A per-port packet source advances on observed handshakes, and accepted
// output beats are logged and compared with hand-derived sequences.
// Define OFS_FIM_PCIE_SS_SB_ARB_STATS_EN to also check pkt_count.
module tb_ofs_fim_pcie_ss_sb_tx_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N*KW-1:0] in_tkeep;
  logic [N-1:0]    in_tlast;
  logic [N*UW-1:0] in_tuser_vendor;
  logic            out_tvalid;
  logic            out_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tlast;
  logic [UW-1:0]   out_tuser_vendor;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef OFS_FIM_PCIE_SS_SB_ARB_STATS_EN
  logic [N*32-1:0] pkt_count;
`endif

  ofs_fim_pcie_ss_sb_tx_arb #(
    .NUM_PORTS   (N),
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .in_tdata         (in_tdata),
    .in_tkeep         (in_tkeep),
    .in_tlast         (in_tlast),
    .in_tuser_vendor  (in_tuser_vendor),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tdata        (out_tdata),
    .out_tkeep        (out_tkeep),
    .out_tlast        (out_tlast),
    .out_tuser_vendor (out_tuser_vendor),
    .grant_id         (grant_id),
    .busy             (busy)
`ifdef OFS_FIM_PCIE_SS_SB_ARB_STATS_EN
    ,
    .pkt_count        (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;

  // Packet sources: remaining packets, packet length, current beat, packet index.
  int src_pkts[N];
  int src_len[N];
  int src_beat[N];
  int src_idx[N];

  // Output-side log of accepted beats.
  int          log_port[$];
  int          log_cyc[$];
  logic [31:0] log_data[$];
  logic [15:0] log_user[$];
  logic [3:0]  log_keep[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int p, input int k, input int b);
    return {8'(p), 8'(k), 8'(b), 8'hA5};
  endfunction

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      in_tvalid[p]                = (src_pkts[p] > 0);
      in_tdata[p*DW +: DW]        = exp_word(p, src_idx[p], src_beat[p]);
      in_tkeep[p*KW +: KW]        = 4'(p + 1);
      in_tlast[p]                 = (src_beat[p] == src_len[p] - 1);
      in_tuser_vendor[p*UW +: UW] = {8'(p), 8'(src_beat[p])};
    end
  endtask

  task automatic start(input int p, input int npkts, input int len);
    src_pkts[p] = npkts;
    src_len[p]  = len;
    src_beat[p] = 0;
    src_idx[p]  = 0;
    drive_inputs();
  endtask

  task automatic clear_log();
    log_port.delete(); log_cyc.delete(); log_data.delete();
    log_user.delete(); log_keep.delete();
  endtask

  // One clock: sample at negedge, then advance sources just after posedge.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = in_tvalid & in_tready;
    if (!busy) check("idle_quiet", {59'd0, in_tready, out_tvalid}, 64'd0);
    check("tready_only_granted", {60'd0, in_tready & ~(4'b0001 << grant_id)}, 64'd0);
    if (out_tvalid && out_tready) begin
      log_port.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
      log_data.push_back(out_tdata);
      log_user.push_back(out_tuser_vendor);
      log_keep.push_back(out_tkeep);
      $display("cyc %0d: port %0d data %h keep %h user %h last %b",
               cyc, grant_id, out_tdata, out_tkeep, out_tuser_vendor, out_tlast);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        src_beat[p]++;
        if (src_beat[p] == src_len[p]) begin
          src_beat[p] = 0;
          src_idx[p]++;
          src_pkts[p]--;
        end
      end
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    out_tready = 1'b1;
    for (int p = 0; p < N; p++) begin
      src_pkts[p] = 0; src_len[p] = 1; src_beat[p] = 0; src_idx[p] = 0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    cyc = 1;
  endtask

  task automatic check_beat(input string tag, input int i, input int port, input int c,
                            input logic [31:0] data);
    if (i >= log_port.size()) begin
      check($sformatf("%s_missing_beat%0d", tag, i), 64'(log_port.size()), 64'(i + 1));
    end else begin
      check($sformatf("%s_port%0d", tag, i), 64'(log_port[i]), 64'(port));
      check($sformatf("%s_cyc%0d", tag, i), 64'(log_cyc[i]), 64'(c));
      check($sformatf("%s_data%0d", tag, i), 64'(log_data[i]), 64'(data));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while requesters are already valid.
    rst        = 1'b1;
    out_tready = 1'b1;
    for (int p = 0; p < N; p++) begin
      src_pkts[p] = 1; src_len[p] = 1; src_beat[p] = 0; src_idx[p] = 0;
    end
    drive_inputs();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);

    // Ports 0 and 1 each send one 1-beat packet.
    reset_dut();
    start(0, 1, 1);
    start(1, 1, 1);
    run(6);
    check("two_count", 64'(log_port.size()), 64'd2);
    check_beat("two", 0, 0, 2, 32'h000000A5);
    check_beat("two", 1, 1, 4, 32'h010000A5);
    if (log_port.size() == 2) begin
      check("two_user0", 64'(log_user[0]), 64'h0000);
      check("two_keep0", 64'(log_keep[0]), 64'h1);
      check("two_user1", 64'(log_user[1]), 64'h0100);
      check("two_keep1", 64'(log_keep[1]), 64'h2);
    end
    check("two_grant_hold", 64'(grant_id), 64'd1);

    // Port 1 sends a 3-beat packet; port 0 becomes valid during beat 1.
    reset_dut();
    start(1, 1, 3);
    run(2);
    start(0, 1, 1);
    run(5);
    check("lock_count", 64'(log_port.size()), 64'd4);
    check_beat("lock", 0, 1, 2, 32'h010000A5);
    check_beat("lock", 1, 1, 3, 32'h010001A5);
    check_beat("lock", 2, 1, 4, 32'h010002A5);
    check_beat("lock", 3, 0, 6, 32'h000000A5);

    // All four ports continuously valid with 1-beat packets.
    reset_dut();
    for (int p = 0; p < N; p++) start(p, 4, 1);
    run(34);
    check("rr_count", 64'(log_port.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check_beat("rr", i, i % 4, 2 + 2 * i, exp_word(i % 4, i / 4, 0));
    end

    // Output back-pressure for 5 cycles in the middle of a 4-beat packet.
    reset_dut();
    start(2, 1, 4);
    run(3);
    out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      #1;
      check($sformatf("stall_grant%0d", i), 64'(grant_id), 64'd2);
      check($sformatf("stall_busy%0d", i), 64'(busy), 64'd1);
      check($sformatf("stall_data%0d", i), 64'(out_tdata), 64'h020002A5);
    end
    out_tready = 1'b1;
    run(4);
    check("stall_count", 64'(log_port.size()), 64'd4);
    check_beat("stall", 0, 2, 2, 32'h020000A5);
    check_beat("stall", 1, 2, 3, 32'h020001A5);
    check_beat("stall", 2, 2, 9, 32'h020002A5);
    check_beat("stall", 3, 2, 10, 32'h020003A5);

    // Reset during beat 2 of a 4-beat packet from port 3.
    reset_dut();
    start(3, 1, 4);
    run(3);
    start(1, 1, 1);
    start(2, 1, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("midrst_in_tready", 64'(in_tready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant", 64'(grant_id), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    cyc = 1;
    run(3);
    check_beat("midrst", 0, 1, 2, 32'h010000A5);

    // Port 0 sends 3 packets, port 1 sends 2: strict alternation, then counters.
    reset_dut();
    start(0, 3, 1);
    start(1, 2, 1);
    run(12);
    check("stats_count", 64'(log_port.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check_beat("stats", i, i % 2, 2 + 2 * i, exp_word(i % 2, i / 2, 0));
    end
`ifdef OFS_FIM_PCIE_SS_SB_ARB_STATS_EN
    check("pkt_count0", 64'(pkt_count[31:0]), 64'd3);
    check("pkt_count1", 64'(pkt_count[63:32]), 64'd2);
    check("pkt_count2", 64'(pkt_count[95:64]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ss_sb_tx_arb.md
OFS_FIM_PCIE_SS_SB_TX_ARB -- requirements
Module: ofs_fim_pcie_ss_sb_tx_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting side-band-header TLP streams (2..8).
REQ-002 SHALL have parameter TDATA_WIDTH, default 512, payload bits per beat.
REQ-003 SHALL have parameter TUSER_WIDTH, default 266, tuser_vendor bits per beat (side-band header in high bits).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_tvalid  input  NUM_PORTS  per-requester beat valid.
REQ-007 SHALL have port in_tready  output  NUM_PORTS  per-requester beat accept.
REQ-008 SHALL have port in_tdata  input  NUM_PORTS*TDATA_WIDTH  per-requester payload, port i at slice i.
REQ-009 SHALL have port in_tkeep  input  NUM_PORTS*TDATA_WIDTH/8  per-requester byte enables.
REQ-010 SHALL have port in_tlast  input  NUM_PORTS  per-requester end of packet.
REQ-011 SHALL have port in_tuser_vendor  input  NUM_PORTS*TUSER_WIDTH  per-requester side-band header/user bits.
REQ-012 SHALL have port out_tvalid, out_tready, out_tdata, out_tkeep, out_tlast, out_tuser_vendor  (output, input, outputs)  widths as one requester slice  merged stream.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_PORTS) (min 1)  index of currently granted requester.
REQ-014 SHALL have port busy  output  1  high while state is LOCKED.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-016 In IDLE, any in_tvalid high: SHALL select winner round-robin, searching from rr_ptr upward with wrap, register grant_id=winner, go to LOCKED next cycle; no beat transfers in IDLE.
REQ-017 In IDLE with no in_tvalid high, SHALL remain IDLE; grant_id holds its previous value.
REQ-018 In LOCKED, SHALL connect only requester grant_id to out_* combinationally (zero latency); out_tvalid = in_tvalid[grant_id], in_tready[grant_id] = out_tready.
REQ-019 All non-granted in_tready bits SHALL be 0 at all times; all in_tready SHALL be 0 in IDLE.
REQ-020 out_tvalid SHALL be 0 in IDLE; out_tdata/tkeep/tuser_vendor SHALL be passed unmodified (no header realignment).
REQ-021 Grant SHALL be held packet-atomic: on accepted beat with tlast in LOCKED -> IDLE, rr_ptr = (grant_id+1) mod NUM_PORTS.
REQ-022 Accepted non-tlast beats and stalled cycles (valid & !ready, or !valid) SHALL keep LOCKED and grant_id unchanged.
REQ-023 Each packet costs exactly one arbitration bubble cycle; sustained throughput for P-beat packets = P/(P+1).
REQ-024 A single requester continuously valid SHALL be re-granted after each bubble; no requester SHALL wait more than NUM_PORTS-1 packets.

Reset
REQ-025 While rst high: state=IDLE, rr_ptr=0, grant_id=0, busy=0, out_tvalid=0, in_tready=0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet; after release arbitration restarts from port 0 with no partial-packet recovery.

Configuration
REQ-027 Macro OFS_FIM_PCIE_SS_SB_ARB_STATS_EN defined: SHALL add output pkt_count (NUM_PORTS*32) with per-port 32-bit counters incremented on each accepted tlast beat of that port, wrapping 0xFFFFFFFF->0, cleared by rst.
REQ-028 Macro undefined: SHALL omit pkt_count port and counter logic; all other behaviour identical.

Verification
REQ-029 Ports 0,1 each present one 1-beat packet, out_tready=1 -> port 0 transfers cycle 2, port 1 cycle 4, grant_id 0 then 1.
REQ-030 Port 1 sends 3-beat packet, port 0 valid from beat 2 -> port 0 in_tready stays 0 until port 1 tlast accepted, then granted after one bubble.
REQ-031 All 4 ports (NUM_PORTS=4) continuously valid with 1-beat packets -> grant order 0,1,2,3,0,... for 16 packets.
REQ-032 out_tready held 0 for 5 cycles mid-packet -> grant_id, out_tdata, busy stable; no beat lost or duplicated.
REQ-033 rst pulsed during beat 2 of a 4-beat packet -> out_tvalid=0 during rst, next grant to lowest valid port from 0.
REQ-034 With STATS_EN, port 0 sends 3 packets, port 1 sends 2 -> pkt_count slices read 3 and 2.
